// File: rtl/instr_sequencer.sv
// Program sequencer: holds a small instruction store and issues its contents to the
// ALU datapath over a valid/ready handshake, with repeat passes, single-step and abort.
module instr_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int INSTR_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic [7:0]         repeat_cnt,
  input  logic               step_mode,
  input  logic               step,
  input  logic               start,
  input  logic               abort,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic [7:0]         iter,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  state_t state;
  state_t next_state;

  logic [INSTR_W-1:0] store [PROG_DEPTH];
  logic [ADDR_W:0]    len;
  logic [7:0]         rep;
  logic               step_lat;
  logic [ADDR_W:0]    start_len;
  logic               xfer;
  logic               last_pc;
  logic               last_pass;
  logic               active;

  // Program length clamped to the store depth, evaluated at start.
  assign start_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign xfer      = issue_valid & issue_ready;
  assign last_pc   = ({1'b0, pc} == (len - ONE_L));
  assign last_pass = (iter == rep);
  assign active    = (state == ISSUE) || (state == HOLD);

  // Instruction store: cleared on reset, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        store[i] <= {INSTR_W{1'b0}};
      end
    end else if ((state == IDLE) && load_en) begin
      store[load_addr] <= load_data;
    end else begin
      store[load_addr] <= store[load_addr];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort takes priority over any coincident transfer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (start_len == {(ADDR_W + 1){1'b0}}) ? DONE : ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (xfer) begin
          if (last_pc && last_pass) begin
            next_state = DONE;
          end else if (step_lat) begin
            next_state = HOLD;
          end else begin
            next_state = ISSUE;
          end
        end else begin
          next_state = ISSUE;
        end
      end
      HOLD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (step) begin
          next_state = ISSUE;
        end else begin
          next_state = HOLD;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Run parameters, program counter, pass counter and the abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= {(ADDR_W + 1){1'b0}};
      rep      <= 8'd0;
      step_lat <= 1'b0;
      pc       <= {ADDR_W{1'b0}};
      iter     <= 8'd0;
      aborted  <= 1'b0;
    end else begin
      aborted <= active & abort;
      if ((state == IDLE) && start) begin
        len      <= start_len;
        rep      <= repeat_cnt;
        step_lat <= step_mode;
        pc       <= {ADDR_W{1'b0}};
        iter     <= 8'd0;
      end else if ((state == ISSUE) && xfer && !abort) begin
        if (!last_pc) begin
          pc <= pc + ADDR_W'(1);
        end else if (!last_pass) begin
          pc   <= {ADDR_W{1'b0}};
          iter <= iter + 8'd1;
        end else begin
          // Final transfer: pc and iter keep their last values for inspection.
          pc   <= pc;
          iter <= iter;
        end
      end else begin
        pc   <= pc;
        iter <= iter;
      end
    end
  end

  // Outputs decoded from state; instruction is a combinational store read.
  always_comb begin
    issue_valid = 1'b0;
    instruction = {INSTR_W{1'b0}};
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ISSUE: begin
        issue_valid = 1'b1;
        instruction = store[pc];
        busy        = 1'b1;
      end
      HOLD: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      IDLE: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
